// File: rtl/branch_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_flag_unit
// Purpose  : Latches ALU NZCV flags and resolves LEGv8 branches (B.cond,
//            CBZ, CBNZ, B). A B.cond that depends on a flag-setting op still
//            in flight waits in WAIT_FLAGS until that op's flags arrive.
// Revision : 1.0  initial release
// ============================================================================
module branch_flag_unit #(
    parameter int DATA_WIDTH  = 64,
    parameter int FORWARD_EN  = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flagWrite,
    input  logic                   negativeFlag,
    input  logic                   zeroFlag,
    input  logic                   carryFlag,
    input  logic                   overflowFlag,
    input  logic                   flagPending,
    input  logic                   brValid,
    output logic                   brReady,
    input  logic [1:0]             brType,
    input  logic [3:0]             brCond,
    input  logic                   operandZero,
    input  logic [DATA_WIDTH-1:0]  pc,
    input  logic [DATA_WIDTH-1:0]  offset,
    output logic                   branchValid,
    output logic                   branchTaken,
    output logic [DATA_WIDTH-1:0]  branchTarget,
    output logic [3:0]             flagsOut,
    output logic [STALL_CNT_W-1:0] stallCount
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [1:0] BT_COND = 2'b00;
    localparam logic [1:0] BT_CBZ  = 2'b01;
    localparam logic [1:0] BT_CBNZ = 2'b10;

    // Evaluate an ARM condition code against flags packed as {N,Z,C,V}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~(c & ~z);
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = ~(~z & (n == v));
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    logic [0:0]            state;
    logic [3:0]            held_cond;
    logic [DATA_WIDTH-1:0] held_pc;
    logic [DATA_WIDTH-1:0] held_offset;

    logic [3:0] alu_flags;
    logic [3:0] sel_flags;
    logic       accept;
    logic       needs_flags;
    logic       imm_taken;

    assign alu_flags = {negativeFlag, zeroFlag, carryFlag, overflowFlag};
    assign brReady   = (state == S_IDLE);
    assign accept    = brValid & brReady;

    // Forwarding lets a B.cond see the flags being written this very cycle
    assign sel_flags = (flagWrite && (FORWARD_EN != 0)) ? alu_flags : flagsOut;

    // A concurrent flagWrite satisfies the pending op, so no stall then
    assign needs_flags = (brType == BT_COND) && (brCond[3:1] != 3'b111)
                         && flagPending && !flagWrite;

    // Taken decision for a request resolved in the cycle it is accepted
    always_comb begin
        imm_taken = 1'b1;
        case (brType)
            BT_COND: imm_taken = cond_eval(brCond, sel_flags);
            BT_CBZ:  imm_taken = operandZero;
            BT_CBNZ: imm_taken = ~operandZero;
            default: imm_taken = 1'b1;
        endcase
    end

    // Architectural flag register, updated by every flag-setting ALU result
    always_ff @(posedge clk) begin
        if (reset) begin
            flagsOut <= 4'b0000;
        end else if (flagWrite) begin
            flagsOut <= alu_flags;
        end
    end

    // Request FSM and resolution outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            held_cond    <= 4'b0000;
            held_pc      <= '0;
            held_offset  <= '0;
            branchValid  <= 1'b0;
            branchTaken  <= 1'b0;
            branchTarget <= '0;
        end else begin
            branchValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (needs_flags) begin
                            held_cond   <= brCond;
                            held_pc     <= pc;
                            held_offset <= offset;
                            state       <= S_WAIT;
                        end else begin
                            branchValid  <= 1'b1;
                            branchTaken  <= imm_taken;
                            branchTarget <= pc + (offset << 2);
                        end
                    end
                end
                S_WAIT: begin
                    if (flagWrite) begin
                        branchValid  <= 1'b1;
                        branchTaken  <= cond_eval(held_cond, alu_flags);
                        branchTarget <= held_pc + (held_offset << 2);
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of cycles spent waiting for flags
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if ((state == S_WAIT) && (stallCount != {STALL_CNT_W{1'b1}})) begin
            stallCount <= stallCount + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_flag_unit
// Purpose  : Directed bench for branch_flag_unit with a reference model.
//            Two instances (forwarding on / off) share all inputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_flag_unit;

    localparam int DW = 64;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          flagWrite, nf, zf, cf, vf, flagPending;
    logic          brValid;
    logic [1:0]    brType;
    logic [3:0]    brCond;
    logic          operandZero;
    logic [DW-1:0] pc, offset;

    logic          rdy [2];
    logic          bv  [2];
    logic          bt  [2];
    logic [DW-1:0] tgt [2];
    logic [3:0]    fo  [2];
    logic [SW-1:0] sc  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_flag_unit #(.DATA_WIDTH(DW), .FORWARD_EN(1), .STALL_CNT_W(SW)) u_fwd (
        .clk(clk), .reset(reset), .flagWrite(flagWrite),
        .negativeFlag(nf), .zeroFlag(zf), .carryFlag(cf), .overflowFlag(vf),
        .flagPending(flagPending), .brValid(brValid), .brReady(rdy[0]),
        .brType(brType), .brCond(brCond), .operandZero(operandZero),
        .pc(pc), .offset(offset), .branchValid(bv[0]), .branchTaken(bt[0]),
        .branchTarget(tgt[0]), .flagsOut(fo[0]), .stallCount(sc[0])
    );

    branch_flag_unit #(.DATA_WIDTH(DW), .FORWARD_EN(0), .STALL_CNT_W(SW)) u_nofwd (
        .clk(clk), .reset(reset), .flagWrite(flagWrite),
        .negativeFlag(nf), .zeroFlag(zf), .carryFlag(cf), .overflowFlag(vf),
        .flagPending(flagPending), .brValid(brValid), .brReady(rdy[1]),
        .brType(brType), .brCond(brCond), .operandZero(operandZero),
        .pc(pc), .offset(offset), .branchValid(bv[1]), .branchTaken(bt[1]),
        .branchTarget(tgt[1]), .flagsOut(fo[1]), .stallCount(sc[1])
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Condition = base predicate selected by cond[3:1], inverted by cond[0];
    // pair 111 is "always".
    function automatic bit cond_true(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (cond[3:1] == 3'b111) return 1'b1;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ cond[0];
    endfunction

    bit            m_waiting;
    logic [3:0]    m_cond;
    logic [DW-1:0] m_target_saved;
    logic [3:0]    m_flags;
    int            m_stall;
    bit            m_valid;
    bit            m_taken [2];
    logic [DW-1:0] m_target;

    always @(posedge clk) begin
        logic [3:0] alu;
        alu = {nf, zf, cf, vf};
        m_valid = 1'b0;
        if (reset) begin
            m_waiting = 0; m_flags = 4'b0; m_stall = 0;
            m_taken[0] = 0; m_taken[1] = 0; m_target = '0;
        end else begin
            if (m_waiting) begin
                if (m_stall < 65535) m_stall++;
                if (flagWrite) begin
                    m_waiting = 0;
                    m_valid = 1'b1;
                    m_taken[0] = cond_true(m_cond, alu);
                    m_taken[1] = m_taken[0];
                    m_target = m_target_saved;
                end
            end else if (brValid) begin
                if (brType == 2'b00 && !cond_true_always(brCond) && flagPending && !flagWrite) begin
                    m_waiting = 1;
                    m_cond = brCond;
                    m_target_saved = pc + offset * 4;
                end else begin
                    m_valid = 1'b1;
                    m_target = pc + offset * 4;
                    for (int k = 0; k < 2; k++) begin
                        case (brType)
                            2'b00: m_taken[k] = cond_true(brCond,
                                       (flagWrite && k == 0) ? alu : m_flags);
                            2'b01: m_taken[k] = operandZero;
                            2'b10: m_taken[k] = !operandZero;
                            default: m_taken[k] = 1'b1;
                        endcase
                    end
                end
            end
            if (flagWrite) m_flags = alu;
        end
    end

    function automatic bit cond_true_always(input logic [3:0] cond);
        return cond == 4'hE || cond == 4'hF;
    endfunction

    // Per-cycle comparison of both instances against the model
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("m_ready%0d", k), DW'(rdy[k]), DW'(!m_waiting));
            check($sformatf("m_valid%0d", k), DW'(bv[k]), DW'(m_valid));
            check($sformatf("m_taken%0d", k), DW'(bt[k]), DW'(m_taken[k]));
            check($sformatf("m_target%0d", k), tgt[k], m_target);
            check($sformatf("m_flags%0d", k), DW'(fo[k]), DW'(m_flags));
            check($sformatf("m_stall%0d", k), DW'(sc[k]), DW'(m_stall));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        flagWrite = 0; {nf, zf, cf, vf} = 4'b0; brValid = 0;
        brType = 2'b00; brCond = 4'b0; operandZero = 0; pc = '0; offset = '0;
    endtask

    task automatic set_req(input logic [1:0] t, input logic [3:0] c,
                           input logic oz, input logic [DW-1:0] p, input logic [DW-1:0] o);
        brValid = 1; brType = t; brCond = c; operandZero = oz; pc = p; offset = o;
    endtask

    task automatic write_flags(input logic [3:0] f);
        @(negedge clk);
        idle_inputs();
        flagWrite = 1; {nf, zf, cf, vf} = f;
        @(negedge clk);
        idle_inputs();
    endtask

    // One request in one cycle; returns with outputs of its resolution visible
    task automatic branch(input logic [1:0] t, input logic [3:0] c,
                          input logic oz, input logic [DW-1:0] p, input logic [DW-1:0] o);
        set_req(t, c, oz, p, o);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset = 1; flagPending = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
        check("rst_ready", DW'(rdy[0]), 1);
        check("rst_flags", DW'(fo[0]), 0);
        check("rst_stall", DW'(sc[0]), 0);
        check("rst_valid", DW'(bv[0]), 0);

        // 0xFFFF..FF + 1: N=0 Z=1 C=1 V=0
        write_flags(4'b0110);
        branch(2'b00, 4'b0000, 0, 64'h100, 64'd4);
        check("beq_valid", DW'(bv[0]), 1);
        check("beq_taken", DW'(bt[0]), 1);
        check("beq_target", tgt[0], 64'h110);
        check("beq_flags", DW'(fo[0]), 4'b0110);
        branch(2'b00, 4'b1000, 0, 64'h100, 64'd4);
        check("bhi_taken", DW'(bt[0]), 0);

        // 0x8000.. + 0x8000..: N=0 Z=1 C=1 V=1
        write_flags(4'b0111);
        branch(2'b00, 4'b1010, 0, 64'h200, 64'd1);
        check("bge_taken", DW'(bt[0]), 0);
        branch(2'b00, 4'b1011, 0, 64'h200, 64'd1);
        check("blt_taken", DW'(bt[0]), 1);
        branch(2'b00, 4'b0110, 0, 64'h200, 64'd1);
        check("bvs_taken", DW'(bt[0]), 1);

        // Stall: B.MI waits three cycles for 0x5000..-0x6000.. (N=1)
        flagPending = 1;
        set_req(2'b00, 4'b0100, 0, 64'h1000, 64'h10);
        @(negedge clk); idle_inputs();
        check("stall_ready1", DW'(rdy[0]), 0);
        @(negedge clk);
        check("stall_ready2", DW'(rdy[0]), 0);
        @(negedge clk);
        check("stall_ready3", DW'(rdy[0]), 0);
        flagWrite = 1; {nf, zf, cf, vf} = 4'b1000;
        @(negedge clk); idle_inputs(); flagPending = 0;
        check("stall_valid", DW'(bv[0]), 1);
        check("stall_taken", DW'(bt[0]), 1);
        check("stall_target", tgt[0], 64'h1040);
        check("stall_count", DW'(sc[0]), 3);
        check("stall_ready_after", DW'(rdy[0]), 1);

        // Always-true code with flagPending never stalls
        flagPending = 1;
        branch(2'b00, 4'b1110, 0, 64'h40, 64'd2);
        flagPending = 0;
        check("bal_valid", DW'(bv[0]), 1);
        check("bal_taken", DW'(bt[0]), 1);

        // Forwarding: flagsOut=0000, then flagWrite Z=1 with B.EQ same cycle
        write_flags(4'b0000);
        flagPending = 1;
        set_req(2'b00, 4'b0000, 0, 64'h300, 64'd1);
        flagWrite = 1; {nf, zf, cf, vf} = 4'b0100;
        @(negedge clk); idle_inputs(); flagPending = 0;
        check("fwd_on_taken", DW'(bt[0]), 1);
        check("fwd_off_taken", DW'(bt[1]), 0);
        check("fwd_off_valid", DW'(bv[1]), 1);

        // Wrap-around target on unconditional B
        branch(2'b11, 4'b0000, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1);
        check("wrap_target", tgt[0], 64'h0);
        check("wrap_taken", DW'(bt[0]), 1);

        // Back-to-back CBZ then CBNZ, operand zero
        set_req(2'b01, 4'b0000, 1, 64'h500, 64'd3);
        @(negedge clk);
        check("cbz_taken", DW'(bt[0]), 1);
        set_req(2'b10, 4'b0000, 1, 64'h504, 64'd3);
        @(negedge clk); idle_inputs();
        check("cbnz_valid", DW'(bv[0]), 1);
        check("cbnz_taken", DW'(bt[0]), 0);
        check("cbnz_target", tgt[0], 64'h510);

        // Reset while in WAIT_FLAGS
        flagPending = 1;
        set_req(2'b00, 4'b0000, 0, 64'h600, 64'd1);
        @(negedge clk); idle_inputs();
        check("rw_ready", DW'(rdy[0]), 0);
        reset = 1;
        @(negedge clk);
        reset = 0; flagPending = 0;
        check("rw_ready_after", DW'(rdy[0]), 1);
        check("rw_flags", DW'(fo[0]), 0);
        check("rw_stall", DW'(sc[0]), 0);
        flagWrite = 1; {nf, zf, cf, vf} = 4'b0100;
        @(negedge clk); idle_inputs();
        check("rw_no_valid", DW'(bv[0]), 0);
        repeat (2) @(negedge clk);
        check("rw_no_valid2", DW'(bv[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Consumer end of the 64-bit ALU flag interface.
- Captures the NZCV flags (negativeFlag, zeroFlag, carryFlag, overflowFlag) produced by flag-setting ALU ops into an architectural flag register.
- Resolves LEGv8 conditional branches (B.cond, CBZ, CBNZ, B) against those flags and computes the branch target.
- Sits between EX (ALU outputs) and the fetch PC mux; stalls branch requests while a flag-setting op is still in flight.

Parameters:
- DATA_WIDTH, 64, width of pc, offset and branchTarget.
- FORWARD_EN, 1, 1 = a B.cond accepted in the same cycle as flagWrite uses the incoming ALU flags; 0 = it uses the registered flags.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flagWrite  in  1  ALU result valid for an op that sets flags; latch the four flags this cycle
- negativeFlag, zeroFlag, carryFlag, overflowFlag  in  1 each  ALU flags
- flagPending  in  1  a flag-setting op is issued but has not yet produced flagWrite
- brValid  in  1  branch request valid
- brReady  out  1  unit can accept a request
- brType  in  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional)
- brCond  in  4  condition code for B.cond
- operandZero  in  1  register operand of CBZ/CBNZ is zero (sampled at accept)
- pc  in  DATA_WIDTH  address of the branch instruction
- offset  in  DATA_WIDTH  sign-extended word offset
- branchValid  out  1  one-cycle pulse: resolution result valid
- branchTaken  out  1  branch taken (qualified by branchValid)
- branchTarget  out  DATA_WIDTH  pc + (offset << 2), modulo 2^DATA_WIDTH
- flagsOut  out  4  registered {N,Z,C,V}
- stallCount  out  STALL_CNT_W  total WAIT_FLAGS cycles; saturates at all-ones

Behaviour:
- All state changes occur on the rising edge of clk. An accept happens in any cycle where brValid & brReady.
- Reset, at any time including mid-WAIT_FLAGS:
  - FSM goes to IDLE; any held request is dropped.
  - flagsOut=0, branchValid=0, branchTaken=0, branchTarget=0, stallCount=0.
  - brReady=1 in the first cycle after reset deasserts.
- Flag register: on flagWrite, flagsOut <= {N,Z,C,V} from the ALU inputs, in every state. Otherwise it holds.
- FSM states:
  - IDLE: brReady=1.
    - On accept of a B.cond whose brCond is not 1110/1111, with flagPending=1 and flagWrite=0: capture brCond, pc and offset, then go to WAIT_FLAGS.
    - Every other accept resolves immediately. branchValid=1 the next cycle (latency 1) and the FSM stays in IDLE, so back-to-back accepts are allowed.
  - WAIT_FLAGS: brReady=0; stallCount increments each cycle (saturating).
    - When flagWrite=1: resolve the captured request using the incoming ALU flags. branchValid=1 the next cycle, then return to IDLE.
- branchValid is high for exactly one cycle per accepted request. branchTaken and branchTarget hold their values until the next resolution.
- Flag selection for an immediate B.cond:
  - If flagWrite=1 and FORWARD_EN=1, use the incoming ALU flags.
  - Otherwise use flagsOut.
  - A flagWrite concurrent with an accept that has flagPending=1 counts as satisfying the pending write (no stall).
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 HS C; 0011 LO !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !(C&!Z)
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V))
  - 1110 and 1111: always taken
- Other branch types: CBZ taken = operandZero; CBNZ taken = !operandZero; B is always taken. None of these ever stall.
- Target arithmetic: branchTarget is computed for every resolution regardless of whether the branch is taken. The offset is shifted left by 2 and added unsigned; carry-out is discarded (wrap-around).

Test Plan:
- Flags from 0xFFFFFFFFFFFFFFFF+1 (N=0,Z=1,C=1,V=0) with flagWrite. Next cycle, B.EQ with pc=0x100, offset=4 -> branchTaken=1, branchTarget=0x110, flagsOut=0110. Then B.HI with the same flags -> not taken.
- Flags from 0x8000000000000000+0x8000000000000000 (Z=1,C=1,V=1,N=0): B.GE -> not taken; B.LT -> taken; B.VS -> taken.
- Stall case:
  - Stimulus: flagPending=1 when B.MI is accepted; flagWrite arrives 3 cycles later with flags from 0x5000000000000000-0x6000000000000000 (N=1).
  - Required: brReady=0 for 3 cycles, then branchValid with taken=1; stallCount increments by 3.
- Forwarding: flagWrite with Z=1 and B.EQ accepted in the same cycle, flagsOut=0000 beforehand -> taken with FORWARD_EN=1, not taken with FORWARD_EN=0.
- Wrap and other types:
  - pc=0xFFFFFFFFFFFFFFFC, offset=1 -> branchTarget=0x0.
  - Back-to-back CBZ(operandZero=1) then CBNZ(operandZero=1) -> taken, then not taken on consecutive cycles.
- Reset in WAIT_FLAGS -> no branchValid pulse follows; flagsOut=0, stallCount=0, brReady=1.
